instr_fetch: RTL and testbench

//  Multicycle instruction fetch stage of the 8-bit MIPS CPU, directly upstream of the control unit FSM.

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Multicycle instruction fetch for the 8-bit MIPS CPU: reads four bytes from
// byte-wide synchronous memory, assembles a little-endian 32-bit word, and hands it on with valid/ready.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    RST  = 3'd0,
    F0   = 3'd1,
    F1   = 3'd2,
    F2   = 3'd3,
    F3   = 3'd4,
    CAP  = 3'd5,
    HOLD = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [23:0]       shadow_q, shadow_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] redirectTarget;
  logic [1:0]        unusedRedirectLsbs;

  assign redirectTarget     = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unusedRedirectLsbs = redirect_pc[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RST;
      pc_q     <= RESET_PC;
      shadow_q <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      shadow_q <= shadow_d;
      instr_q  <= instr_d;
    end
  end

  // Each Fk cycle picks up the byte requested in the previous cycle; the
  // last byte goes straight into instr in CAP.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    shadow_d = shadow_q;
    instr_d  = instr_q;
    unique case (state_q)
      RST: state_d = F0;
      F0:  state_d = F1;
      F1: begin
        shadow_d[7:0] = mem_rdata;
        state_d       = F2;
      end
      F2: begin
        shadow_d[15:8] = mem_rdata;
        state_d        = F3;
      end
      F3: begin
        shadow_d[23:16] = mem_rdata;
        state_d         = CAP;
      end
      CAP: begin
        instr_d = {mem_rdata, shadow_q};
        state_d = HOLD;
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = F0;
        end
      end
      default: state_d = RST;
    endcase

    // A redirect overrides everything above, including a same-cycle accept
    // and a CAP write, so abandoned bytes never reach instr.
    if (redirect_valid && (state_q != RST)) begin
      pc_d     = redirectTarget;
      shadow_d = '0;
      instr_d  = instr_q;
      state_d  = F0;
    end
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = pc_q;
    unique case (state_q)
      F0: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
      end
      F1: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + ADDR_W'(1);
      end
      F2: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + ADDR_W'(2);
      end
      F3: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + ADDR_W'(3);
      end
      default: begin
        mem_rd   = 1'b0;
        mem_addr = pc_q;
      end
    endcase
  end

  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + ADDR_W'(4);
  assign instr_valid = (state_q == HOLD);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch: the driver predicts each presented
// instruction from a memory image, and a negedge monitor pops and checks it.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [7:0]  pc;
  logic [7:0]  pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk),
    .reset(reset),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .instr(instr),
    .opcode(opcode),
    .funct(funct),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } expT;

  logic [7:0] mem [256];
  expT        expQ[$];
  expT        cur;
  int         assertCount = 0;
  int         failCount = 0;
  logic [7:0] modelPc;
  logic       prevValid = 1'b0;

  // Synchronous byte memory; junk is driven when no read is requested so a
  // stray capture shows up as a wrong instruction.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 8'($urandom);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelInstr(input logic [7:0] addr);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[(int'(addr) + k) % 256];
    return w;
  endfunction

  // Monitor: each rising instr_valid presents one instruction to be popped;
  // while it stays valid the presented values must not move.
  always @(negedge clk) begin
    if (!reset) begin
      prevValid = 1'b0;
    end else begin
      if (instr_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpectedInstr: got instr 0x%08h pc 0x%02h, expected none at %0t", instr, pc, $time);
        end else begin
          cur = expQ.pop_front();
          checkOutput("instr", instr, cur.instr);
          checkOutput("opcode", 32'(opcode), 32'(cur.instr[31:26]));
          checkOutput("funct", 32'(funct), 32'(cur.instr[5:0]));
          checkOutput("pc", 32'(pc), 32'(cur.pc));
          checkOutput("pcPlus4", 32'(pc_plus4), (int'(cur.pc) + 4) % 256);
          checkOutput("holdMemRd", 32'(mem_rd), 32'd0);
        end
      end else if (instr_valid) begin
        checkOutput("holdInstr", instr, cur.instr);
        checkOutput("holdPc", 32'(pc), 32'(cur.pc));
        checkOutput("holdMemRd", 32'(mem_rd), 32'd0);
      end
      prevValid = instr_valid;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Redirect for len cycles; the first uses tgt, later ones random targets.
  // Returns one cycle into F0 of the new fetch.
  task automatic doRedirect(input int len, input logic [7:0] tgt);
    for (int i = 0; i < len; i++) begin
      redirect_valid = 1'b1;
      redirect_pc    = (i == 0) ? tgt : 8'($urandom);
      modelPc        = {redirect_pc[7:2], 2'b00};
      step();
    end
    redirect_valid = 1'b0;
    checkOutput("validAfterRedirect", 32'(instr_valid), 32'd0);
  endtask

  // Called in the first cycle of F0. redirAt 0..4 abandons the fetch at that
  // cycle; otherwise the word is held for holdCycles, then accepted (with an
  // optional same-cycle redirect) or dropped by a redirect.
  task automatic applyStimulus(input int redirAt, input logic [7:0] redirTgt, input int redirLen,
                               input int holdCycles, input bit acceptRedirect, input bit dropInHold);
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        checkOutput("fetchRd", 32'(mem_rd), 32'd1);
        checkOutput("fetchAddr", 32'(mem_addr), (int'(modelPc) + k) % 256);
      end else begin
        checkOutput("capValid", 32'(instr_valid), 32'd0);
        checkOutput("capRd", 32'(mem_rd), 32'd0);
      end
      instr_ready = 1'($urandom);
      if (k == redirAt) begin
        doRedirect(redirLen, redirTgt);
        return;
      end
      if (k == 4) expQ.push_back('{modelInstr(modelPc), modelPc});
      step();
    end
    checkOutput("latencyValid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b0;
    repeat (holdCycles) step();
    if (dropInHold || acceptRedirect) begin
      instr_ready = acceptRedirect;
      doRedirect(redirLen, redirTgt);
    end else begin
      instr_ready = 1'b1;
      step();
      modelPc = 8'((int'(modelPc) + 4) % 256);
      checkOutput("validDrop", 32'(instr_valid), 32'd0);
    end
    instr_ready = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Valid"}, 32'(instr_valid), 32'd0);
    checkOutput({tag, "MemRd"}, 32'(mem_rd), 32'd0);
    checkOutput({tag, "MemAddr"}, 32'(mem_addr), 32'h00);
    checkOutput({tag, "Pc"}, 32'(pc), 32'h00);
    checkOutput({tag, "Instr"}, instr, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h20;
    mem[1] = 8'h08;
    mem[2] = 8'h05;
    mem[3] = 8'h00;

    reset          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    #3;
    checkResetOutputs("reset");
    step();
    step();
    reset = 1'b1;
    checkOutput("rstStateRd", 32'(mem_rd), 32'd0);
    step();
    modelPc = 8'h00;

    $display("[TB] basic fetch and backpressure");
    checkOutput("basicModelWord", modelInstr(8'h00), 32'h00050820);
    applyStimulus(-1, 8'h00, 1, 0, 1'b0, 1'b0);
    applyStimulus(-1, 8'h00, 1, 10, 1'b0, 1'b0);

    $display("[TB] reset in the middle of F2");
    instr_ready = 1'b1;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    checkResetOutputs("midReset");
    step();
    reset = 1'b1;
    checkOutput("rstAfterRelease", 32'(mem_rd), 32'd0);
    step();
    instr_ready = 1'b0;
    modelPc = 8'h00;

    $display("[TB] redirect mid-fetch, wrap, accept with redirect");
    applyStimulus(2, 8'h43, 1, 0, 1'b0, 1'b0);
    applyStimulus(-1, 8'h00, 1, 2, 1'b0, 1'b0);
    applyStimulus(0, 8'hFF, 1, 0, 1'b0, 1'b0);
    applyStimulus(-1, 8'h00, 1, 1, 1'b0, 1'b0);
    applyStimulus(-1, 8'h00, 1, 0, 1'b0, 1'b0);
    applyStimulus(-1, 8'h10, 1, 3, 1'b1, 1'b0);
    applyStimulus(-1, 8'h20, 1, 2, 1'b0, 1'b1);
    applyStimulus(3, 8'h80, 3, 0, 1'b0, 1'b0);
    applyStimulus(4, 8'h30, 1, 0, 1'b0, 1'b0);

    $display("[TB] randomised fetch sequence");
    for (int n = 0; n < 150; n++) begin
      int  redirAt;
      int  sel;
      sel     = $urandom_range(0, 9);
      redirAt = (sel < 3) ? $urandom_range(0, 4) : -1;
      applyStimulus(redirAt, 8'($urandom), $urandom_range(1, 2), $urandom_range(0, 6),
                    (sel == 3), (sel == 4));
    end

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
